// File: rtl/switch_pkg.sv
// Shared definitions for the switch input path and the LED pattern decoder.
package switch_pkg;

  // Switch bus width seen by both the debouncer and the LED decoder.
  localparam int SWITCH_WIDTH = 3;

  // Debounce FSM states.
  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } sw_state_e;

endpackage : switch_pkg

// File: rtl/bit_sync.sv
// Parameterised N-stage, WIDTH-bit synchroniser for asynchronous pin inputs.
// Every flop resets asynchronously (active-low) to RESET_VALUE.
module bit_sync #(
  parameter int                 WIDTH       = 1,
  parameter int                 STAGES      = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the pin value through the flop chain; the last stage is the safe output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= RESET_VALUE;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : bit_sync

// File: rtl/switch_debounce.sv
// Slide-switch conditioning: synchronises the raw pins, then debounces the bus
// as a single word. The committed value only changes after DEBOUNCE_CYCLES
// consecutive identical synchronised samples; a one-cycle strobe marks commits.
//
// Handshake: there is no valid/ready pair. `changed` is a one-cycle
// qualifier for `switch`: it is high exactly in the first cycle `switch`
// shows a newly committed value, and never while `enable` is low.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int               WIDTH           = SWITCH_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] raw_switch,
  output logic [WIDTH-1:0] switch,
  output logic             changed,
  output logic             settling
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // A single qualifying sample is enough: commit straight from STABLE.
  localparam bit               COMMIT_NOW = (DEBOUNCE_CYCLES == 1);

  logic [WIDTH-1:0] s;
  sw_state_e        state_q;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] switch_q;
  logic             changed_q;
  logic             settling_q;

  bit_sync #(
    .WIDTH       (WIDTH),
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (raw_switch),
    .q_o    (s)
  );

  // Debounce FSM with registered outputs; all state holds while enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= STABLE;
      cand_q     <= RESET_VALUE;
      cnt_q      <= '0;
      switch_q   <= RESET_VALUE;
      changed_q  <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (enable) begin
        case (state_q)
          STABLE: begin
            if (s != switch_q) begin
              if (COMMIT_NOW) begin
                switch_q  <= s;
                changed_q <= 1'b1;
              end else begin
                cand_q     <= s;
                cnt_q      <= CNT_ONE;
                state_q    <= SETTLE;
                settling_q <= 1'b1;
              end
            end
          end
          SETTLE: begin
            if (s == cand_q) begin
              if (cnt_q == CNT_LAST) begin
                // Candidate has been seen DEBOUNCE_CYCLES times in a row.
                switch_q   <= cand_q;
                changed_q  <= 1'b1;
                cnt_q      <= '0;
                state_q    <= STABLE;
                settling_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_ONE;
              end
            end else if (s == switch_q) begin
              // Input fell back to the committed value: treat as a glitch.
              cnt_q      <= '0;
              state_q    <= STABLE;
              settling_q <= 1'b0;
            end else begin
              // A different word appeared: qualify it from scratch.
              cand_q <= s;
              cnt_q  <= CNT_ONE;
            end
          end
          default: begin
            cnt_q      <= '0;
            state_q    <= STABLE;
            settling_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign switch   = switch_q;
  assign changed  = changed_q;
  assign settling = settling_q;

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with default parameters
// (3-bit bus, 2 sync stages, 4 debounce cycles, reset value 0).
module tb_switch_debounce;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] raw_switch;
  logic [2:0] switch;
  logic       changed;
  logic       settling;

  int compared;
  int mismatched;

  typedef struct {
    logic       en;
    logic [2:0] raw;
    logic [2:0] sw;
    logic       ch;
    logic       st;
  } vec_t;

  vec_t vecs[$];

  switch_debounce dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .raw_switch (raw_switch),
    .switch     (switch),
    .changed    (changed),
    .settling   (settling)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs change just after an edge, outputs read 1ns after the next edge
  task automatic step(input logic en, input logic [2:0] raw);
    enable     = en;
    raw_switch = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [2:0] raw,
                     input logic [2:0] sw, input logic ch, input logic st);
    vec_t v;
    v.en = en; v.raw = raw; v.sw = sw; v.ch = ch; v.st = st;
    vecs.push_back(v);
  endtask

  // Clean change from `from` to `to`: 7 edges, commit on edge 6, settling on 3..5
  task automatic add_clean(input logic [2:0] from, input logic [2:0] to);
    add(1, to, from, 0, 0);
    add(1, to, from, 0, 0);
    add(1, to, from, 0, 1);
    add(1, to, from, 0, 1);
    add(1, to, from, 0, 1);
    add(1, to, to,   1, 0);
    add(1, to, to,   0, 0);
  endtask

  initial begin
    int pulses;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    enable     = 1'b1;
    raw_switch = 3'b101;

    // Reset behaviour: outputs held at reset values while rst is low
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_switch",   32'(switch),   32'd0);
      check("rst_changed",  32'(changed),  32'd0);
      check("rst_settling", 32'(settling), 32'd0);
    end
    rst = 1'b1;

    // Release: 5 commits on edge 6 with exactly one pulse
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1, 3'd5);
      check($sformatf("rel_switch_e%0d", k),   32'(switch),   (k >= 6) ? 32'd5 : 32'd0);
      check($sformatf("rel_changed_e%0d", k),  32'(changed),  (k == 6) ? 32'd1 : 32'd0);
      check($sformatf("rel_settling_e%0d", k), 32'(settling), (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
      if (changed) pulses++;
    end
    check("rel_pulse_count", 32'(pulses), 32'd1);

    // Vector table
    add_clean(3'd5, 3'd2);
    // Glitch: 7 for two cycles, back to 2
    add(1, 3'd7, 3'd2, 0, 0);
    add(1, 3'd7, 3'd2, 0, 0);
    add(1, 3'd2, 3'd2, 0, 1);
    add(1, 3'd2, 3'd2, 0, 1);
    add(1, 3'd2, 3'd2, 0, 0);
    add(1, 3'd2, 3'd2, 0, 0);
    add(1, 3'd2, 3'd2, 0, 0);
    add_clean(3'd2, 3'd3);
    // Bounce 3 -> 6 -> 3 -> 6 (2 cycles each), then hold 6
    add(1, 3'd6, 3'd3, 0, 0);
    add(1, 3'd6, 3'd3, 0, 0);
    add(1, 3'd3, 3'd3, 0, 1);
    add(1, 3'd3, 3'd3, 0, 1);
    add(1, 3'd6, 3'd3, 0, 0);
    add(1, 3'd6, 3'd3, 0, 0);
    add(1, 3'd6, 3'd3, 0, 1);
    add(1, 3'd6, 3'd3, 0, 1);
    add(1, 3'd6, 3'd3, 0, 1);
    add(1, 3'd6, 3'd6, 1, 0);
    add(1, 3'd6, 3'd6, 0, 0);
    // Restart: candidate 1 replaced by 2 mid-settle
    add(1, 3'd1, 3'd6, 0, 0);
    add(1, 3'd1, 3'd6, 0, 0);
    add(1, 3'd2, 3'd6, 0, 1);
    add(1, 3'd2, 3'd6, 0, 1);
    add(1, 3'd2, 3'd6, 0, 1);
    add(1, 3'd2, 3'd6, 0, 1);
    add(1, 3'd2, 3'd6, 0, 1);
    add(1, 3'd2, 3'd2, 1, 0);
    add(1, 3'd2, 3'd2, 0, 0);
    // Enable freeze: 2 -> 4, enable low for 5 cycles after 2 qualifying cycles
    add(1, 3'd4, 3'd2, 0, 0);
    add(1, 3'd4, 3'd2, 0, 0);
    add(1, 3'd4, 3'd2, 0, 1);
    add(1, 3'd4, 3'd2, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 3'd4, 3'd2, 0, 1);
    add(1, 3'd4, 3'd2, 0, 1);
    add(1, 3'd4, 3'd4, 1, 0);
    add(1, 3'd4, 3'd4, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].raw);
      check($sformatf("vec%0d_switch", i),   32'(switch),   32'(vecs[i].sw));
      check($sformatf("vec%0d_changed", i),  32'(changed),  32'(vecs[i].ch));
      check($sformatf("vec%0d_settling", i), 32'(settling), 32'(vecs[i].st));
    end

    // Mid-settle reset: candidate 1 is discarded, switch drops asynchronously
    for (int k = 0; k < 4; k++) step(1, 3'd1);
    check("mid_settling_before", 32'(settling), 32'd1);
    check("mid_switch_before",   32'(switch),   32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_switch",   32'(switch),   32'd0);
    check("mid_async_settling", 32'(settling), 32'd0);
    check("mid_async_changed",  32'(changed),  32'd0);
    step(1, 3'd0);
    step(1, 3'd0);
    check("mid_hold_switch", 32'(switch), 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1, 3'd0);
      check($sformatf("post_switch_e%0d", k),   32'(switch),   32'd0);
      check($sformatf("post_changed_e%0d", k),  32'(changed),  32'd0);
      check($sformatf("post_settling_e%0d", k), 32'(settling), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_switch_debounce
